// File: rtl/seg_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg_serial_tx
// Description : Shifts a segment-pattern frame MSB-first into the display's
//               cascaded shift registers, then strobes the latch enable.
//               Optional build macro SEG_AUTO_REFRESH_EN resends automatically
//               whenever the input frame differs from the last one sent.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_serial_tx #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_dt,
    output logic             seg_pen,
    output logic             seg_clr_n
);

    localparam int              BW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   c_div_max  = CW'(DIV - 1);
    localparam logic [BW-1:0]   c_last_bit = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [BW-1:0]    r_bit;
    logic [BW-1:0]    w_bit_nxt;
    logic [CW-1:0]    r_div;
    logic [CW-1:0]    w_div_nxt;
    logic             w_div_end;
    logic             r_dt;
    logic             w_dt_nxt;
    logic             w_go;
    logic             r_busy;
    logic             r_done;
    logic             r_clk;
    logic             r_pen;
    logic             r_clr_n;

`ifdef SEG_AUTO_REFRESH_EN
    logic [WIDTH-1:0] r_last;

    assign w_go = start || (data != r_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= '0;
        end else if (r_state == IDLE && w_go) begin
            r_last <= data;
        end
    end
`else
    assign w_go = start;
`endif

    always_comb begin
        w_next      = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_dt_nxt    = r_dt;
        w_div_end   = (r_div == c_div_max);
        w_div_nxt   = w_div_end ? '0 : r_div + CW'(1);
        case (r_state)
            IDLE: begin
                w_div_nxt = '0;
                if (w_go) begin
                    w_next      = SHIFT_LO;
                    w_shift_nxt = data;
                    w_bit_nxt   = '0;
                    w_dt_nxt    = data[WIDTH-1];
                end
            end
            SHIFT_LO: begin
                if (w_div_end) begin
                    w_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_div_end) begin
                    w_shift_nxt = r_shift << 1;
                    if (r_bit == c_last_bit) begin
                        // last bit stays on the line through the latch pulse
                        w_next = LATCH;
                    end else begin
                        w_bit_nxt = r_bit + BW'(1);
                        w_dt_nxt  = r_shift[WIDTH-2];
                        w_next    = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (w_div_end) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_div_nxt = '0;
                w_next    = IDLE;
            end
            default: begin
                w_div_nxt = '0;
                w_next    = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_dt    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_clk   <= 1'b0;
            r_pen   <= 1'b0;
            r_clr_n <= 1'b0;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_div   <= w_div_nxt;
            r_dt    <= w_dt_nxt;
            r_busy  <= (w_next != IDLE);
            r_done  <= (r_state == DONE);
            r_clk   <= (w_next == SHIFT_HI);
            r_pen   <= (w_next == LATCH);
            r_clr_n <= 1'b1;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign seg_clk   = r_clk;
    assign seg_dt    = r_dt;
    assign seg_pen   = r_pen;
    assign seg_clr_n = r_clr_n;

endmodule
`default_nettype wire

// File: doc/seg_serial_tx.md
Name: seg_serial_tx

Overview:
- Serial transmitter for the 8-digit seven-segment display.
- Consumes the 64-bit segment-pattern word produced by the hex-to-segment decoder (8 bits per digit, digit 0 pattern in bits 63:56).
- Shifts the word out MSB-first onto the board's cascaded shift registers (clock, data, latch/enable, clear), then pulses the latch so all digits update together.
- Sits between the display decoder and the board's segment pins.

Parameters:
- WIDTH, 64, number of bits per frame. Must be a multiple of 8.
- DIV, 4, clk cycles per half-period of seg_clk. DIV >= 1.
- CW, 16, width of the internal divider counter. Must hold DIV-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to send data; sampled only in IDLE.
- data  input  WIDTH  segment-pattern frame; captured on an accepted start.
- busy  output  1  high from the cycle after acceptance until the return to IDLE.
- done  output  1  one-cycle pulse when the frame has been latched.
- seg_clk  output  1  serial shift clock to the shift registers.
- seg_dt  output  1  serial data; valid around each seg_clk rising edge.
- seg_pen  output  1  latch/enable strobe; high pulse after the last bit.
- seg_clr_n  output  1  active-low clear for the shift registers.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; shift register=0; bit counter=0; divider=0.
  - busy=0, done=0, seg_clk=0, seg_dt=0, seg_pen=0, seg_clr_n=0.
- First clk edge after rstn deasserts: seg_clr_n=1, and it stays 1 until the next reset.
- All outputs are registered.
- Asserting rstn mid-frame aborts the frame immediately; no latch pulse is issued.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - busy=0, seg_clk=0, seg_pen=0.
  - On start=1 at edge t: capture data, set seg_dt=data[WIDTH-1], bit counter=0, divider=0, go to SHIFT_LO. busy=1 from edge t.
- SHIFT_LO:
  - seg_clk=0 for DIV cycles.
  - When the divider reaches DIV-1: seg_clk goes 1, go to SHIFT_HI.
- SHIFT_HI:
  - seg_clk=1 for DIV cycles.
  - When the divider reaches DIV-1: seg_clk goes 0 and the shift register shifts left by 1.
  - seg_dt takes the next bit on that same edge, so data changes only at the seg_clk falling edge.
  - If bit counter == WIDTH-1: go to LATCH. Otherwise increment the bit counter and go to SHIFT_LO.
- LATCH:
  - seg_pen=1 for DIV cycles; seg_clk held 0; seg_dt held at its last value.
  - Then seg_pen=0, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - busy falls with done, i.e. busy=0 in the cycle done is high. Next state IDLE.
- Timing: busy is high for WIDTH*2*DIV + DIV + 1 cycles. Default: 64*8 + 4 + 1 = 517 cycles.
- start is ignored while busy, including during LATCH and DONE; no queuing.
- data may change freely after capture without affecting the frame in flight.
- Bit counter width: clog2(WIDTH). Divider resets to 0 on every state change.
- DIV=1 is legal: seg_clk toggles every clk cycle.

Optional Feature:
- Macro: SEG_AUTO_REFRESH_EN.
- Defined:
  - The block keeps a copy of the last transmitted frame.
  - In IDLE, a new frame starts automatically whenever data differs from that copy, exactly as if start had been pulsed.
  - A start pulse also forces a resend even when data is unchanged.
  - After reset the copy is 0, so nonzero data starts a frame one cycle after reset release.
- Undefined:
  - Frames start only on start.
  - No copy register exists.

Test Plan:
- Reset, then start with data=64'h8000_0000_0000_0001, DIV=4:
  - seg_dt=1 on the first seg_clk rise, 0 for rises 2..63, 1 on rise 64.
  - Exactly 64 seg_clk rising edges, then seg_pen high 4 cycles, then done pulse.
  - busy high for 517 cycles.
- Capture check with data=64'hA5C3_0F1E_FFFF_0000: the bench shift-register model captures the serial stream on seg_clk rises and equals the frame when seg_pen rises. seg_dt never changes while seg_clk=1.
- Start pulsed again at cycle 100 of a frame, and data changed to 0 mid-frame: the captured frame is still the original; exactly one done pulse.
- rstn pulled low mid-SHIFT_HI: all outputs reach their reset values without a clk edge, including seg_clr_n=0. No seg_pen pulse; seg_clr_n=1 one edge after release.
- DIV=1, data=64'hFFFF_FFFF_FFFF_FFFF: seg_clk toggles every cycle; busy lasts 130 cycles; 64 ones captured.
- With SEG_AUTO_REFRESH_EN: data steps 0 → 64'h1 → 64'h1 → 64'h2 while idle → exactly 2 frames sent. Start with unchanged data → 1 extra frame.
